// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen: syncs, display enable, coordinates, strobes and the
// frame count. The generator drives it through the master modport; renderers read the slave side.
interface vga_timing_gen_if #(
    parameter int unsigned X_W  = 10,
    parameter int unsigned Y_W  = 10,
    parameter int unsigned FC_W = 8
) ();
    logic            vga_h_sync;
    logic            vga_v_sync;
    logic            display_area;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic            line_start;
    logic            frame_start;
    logic [FC_W-1:0] frame_cnt;

    modport master (
        output vga_h_sync, vga_v_sync, display_area, x, y, line_start, frame_start, frame_cnt
    );

    modport slave (
        input vga_h_sync, vga_v_sync, display_area, x, y, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered, mutually aligned outputs.
// Optional pixel clock-enable input is enabled by defining VGA_TIMING_PIXCE_EN.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned FC_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef VGA_TIMING_PIXCE_EN
    input  logic             pix_ce,
`endif
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic            advance;
`ifdef VGA_TIMING_PIXCE_EN
    assign advance = pix_ce;
`else
    assign advance = 1'b1;
`endif

    logic [X_W-1:0]  h_cnt_q, h_cnt_d;
    logic [Y_W-1:0]  v_cnt_q, v_cnt_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            da_q, da_d;
    logic            ls_q, ls_d;
    logic            fs_q, fs_d;
    logic [FC_W-1:0] fc_out_q, fc_out_d;

    // Compare in 32 bits so sync windows ending exactly at 2^X_W do not truncate.
    logic [31:0]     h_ext, v_ext;
    logic            h_wrap, v_wrap;

    always_comb begin
        h_ext       = 32'(h_cnt_q);
        v_ext       = 32'(v_cnt_q);
        h_wrap      = h_ext >= H_TOTAL - 1;
        v_wrap      = v_ext >= V_TOTAL - 1;

        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        da_d        = da_q;
        ls_d        = 1'b0;
        fs_d        = 1'b0;
        fc_out_d    = fc_out_q;

        if (advance) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + X_W'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + Y_W'(1);
                if (v_wrap) begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end
            end

            // Output stage decodes the pre-advance position, one clk behind the counters.
            x_d      = h_cnt_q;
            y_d      = v_cnt_q;
            da_d     = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
            hs_d     = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
            vs_d     = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
            ls_d     = (h_cnt_q == '0);
            fs_d     = (h_cnt_q == '0) && (v_cnt_q == '0);
            fc_out_d = frame_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            da_q        <= 1'b0;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
            fc_out_q    <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            da_q        <= da_d;
            ls_q        <= ls_d;
            fs_q        <= fs_d;
            fc_out_q    <= fc_out_d;
        end
    end

    assign vga.x            = x_q;
    assign vga.y            = y_q;
    assign vga.vga_h_sync   = hs_q;
    assign vga.vga_v_sync   = vs_q;
    assign vga.display_area = da_q;
    assign vga.line_start   = ls_q;
    assign vga.frame_start  = fs_q;
    assign vga.frame_cnt    = fc_out_q;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator; the successor to the fixed 640x480 sync counter. Produces horizontal/vertical sync with programmable porches and polarity, a display-enable, pixel coordinates, line/frame start strobes and a frame counter, all registered and mutually aligned. Sits between the system clock and the pixel/game renderers (pong paddles, ball, score) that consume x/y/display_area.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- X_W, 10, x counter width; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP must be ≤ 2^X_W
- Y_W, 10, y counter width; V_TOTAL likewise ≤ 2^Y_W
- FC_W, 8, frame counter width
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock-enable (present only with VGA_TIMING_PIXCE_EN)
- vga_h_sync  out  1  horizontal sync, polarity per HS_POL
- vga_v_sync  out  1  vertical sync, polarity per VS_POL
- display_area  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- x  out  X_W  current horizontal position, 0..H_TOTAL-1
- y  out  Y_W  current vertical position, 0..V_TOTAL-1
- line_start  out  1  one-pixel strobe at x == 0
- frame_start  out  1  one-pixel strobe at x == 0, y == 0
- frame_cnt  out  FC_W  completed-frame count, wraps modulo 2^FC_W

## Operation
- Internal counters h_cnt, v_cnt. h_cnt increments each pixel; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 with h wrap goes to 0 and frame_cnt increments (wraps 2^FC_W-1 → 0).
- Output stage registers a decode of the current (h_cnt, v_cnt): x=h_cnt, y=v_cnt; hsync active iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync active iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines, changes at x==0); display_area iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Sync outputs drive HS_POL/VS_POL when active, inverse otherwise.
- No illegal states: counter values ≥ TOTAL (unreachable) force wrap to 0 on next advance.
- reset: h_cnt=v_cnt=0, frame_cnt=0; outputs x=0, y=0, display_area=0, line_start=0, frame_start=0, syncs at inactive level (1 for default polarity). Reset mid-frame takes effect on the next edge regardless of position or pix_ce.

## Timing
- Latency: outputs reflect counter state of the previous advance (1 clk). All outputs aligned to the same pixel.
- First edge with reset low: outputs show (0,0), display_area=1, line_start=1, frame_start=1; counters move to (1,0).
- Line period H_TOTAL pixels; frame period H_TOTAL·V_TOTAL pixels (defaults 800, 420000).
- frame_cnt increments in the same cycle frame_start goes high (value visible alongside frame_start is the new count; first frame after reset shows 0).

## Configuration
- VGA_TIMING_PIXCE_EN defined: pix_ce port exists; counters and output registers advance only on clocks with pix_ce=1, otherwise hold. line_start/frame_start are high for exactly one clk (the cycle after the enabling edge) and cleared on clocks with pix_ce=0. reset overrides pix_ce.
- Undefined: no pix_ce port; behaves as pix_ce tied 1 (one pixel per clk).

## Test plan
- Defaults, reset 5 clk then release -> first output cycle x=0,y=0, display_area=1, line_start=1, frame_start=1, syncs=1, frame_cnt=0.
- Defaults, one line -> vga_h_sync low exactly for x=656..751 (96 clk), display_area low from x=640, x wraps 799→0 with y+1 and line_start each 800 clk.
- Defaults, one frame -> vga_v_sync low for y=490..491 (1600 clk); frame_start every 420000 clk; preload 255 frames -> frame_cnt 255→0.
- Reset asserted at x=300,y=200 -> next cycle outputs reset values; after release sequence restarts at (0,0) with frame_start=1.
- H 8/2/2/2, V 4/1/1/1, HS_POL=1, VS_POL=1 -> hsync high at x=10..11, vsync high for y=5, line 14 clk, frame 98 clk.
- VGA_TIMING_PIXCE_EN, pix_ce toggling every clk -> line period 1600 clk, hsync 192 clk, line_start 1 clk wide, counters frozen while pix_ce=0.
